// File: rtl/wr_full_ctrl.sv
// Write-domain pointer controller for an async FIFO: binary/Gray write pointers,
// read-pointer synchroniser, registered full flag and sticky overflow; optional ALMOST_FULL_EN.
module wr_full_ctrl #(
  parameter int Addr_width = 5,
  parameter int AF_margin  = 2
) (
  input  logic                  Wr_clk,
  input  logic                  rst,
  input  logic                  Wr_en,
  input  logic [Addr_width:0]   Rd_point_gray,
  output logic [Addr_width-1:0] Wr_addr,
  output logic [Addr_width:0]   Wr_point,
  output logic                  Mem_wr_en,
  output logic                  Full_sig,
  output logic                  Ovf_err
`ifdef ALMOST_FULL_EN
  ,
  output logic                  Almost_full
`endif
);

  if (Addr_width < 2) begin : g_bad_aw
    $error("wr_full_ctrl: Addr_width must be at least 2");
  end
  if (AF_margin < 0) begin : g_bad_margin
    $error("wr_full_ctrl: AF_margin must not be negative");
  end

  function automatic logic [Addr_width:0] bin2gray(input logic [Addr_width:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [Addr_width:0] wbin_q;
  logic [Addr_width:0] wbin_d;
  logic [Addr_width:0] wgray_q;
  logic [Addr_width:0] wgray_d;
  logic [Addr_width:0] rq1_q;
  logic [Addr_width:0] rq2_q;
  logic [Addr_width:0] full_cmp_s;
  logic                full_q;
  logic                full_d;
  logic                ovf_q;
  logic                ovf_d;
  logic                acc_s;

  // Write acceptance, next pointers and next flag values
  always_comb begin
    acc_s      = Wr_en & ~full_q & ~rst;
    wbin_d     = wbin_q + {{Addr_width{1'b0}}, acc_s};
    wgray_d    = bin2gray(wbin_d);
    // Full when the next write pointer has lapped the synchronised read pointer once.
    full_cmp_s = {~rq2_q[Addr_width:Addr_width-1], rq2_q[Addr_width-2:0]};
    full_d     = (wgray_d == full_cmp_s);
    ovf_d      = ovf_q | (Wr_en & full_q);
  end

  // Pointer, synchroniser and flag registers
  always_ff @(posedge Wr_clk) begin
    if (rst) begin
      wbin_q  <= {(Addr_width+1){1'b0}};
      wgray_q <= {(Addr_width+1){1'b0}};
      rq1_q   <= {(Addr_width+1){1'b0}};
      rq2_q   <= {(Addr_width+1){1'b0}};
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= Rd_point_gray;
      rq2_q   <= rq1_q;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Wr_addr   = wbin_q[Addr_width-1:0];
  assign Wr_point  = wgray_q;
  assign Mem_wr_en = acc_s;
  assign Full_sig  = full_q;
  assign Ovf_err   = ovf_q;

`ifdef ALMOST_FULL_EN
  localparam int PW = Addr_width + 1;
  localparam logic [Addr_width:0] AF_THRESH = PW'((2 ** Addr_width) - AF_margin);

  function automatic logic [Addr_width:0] gray2bin(input logic [Addr_width:0] g);
    logic [Addr_width:0] b;
    b[Addr_width] = g[Addr_width];
    for (int i = Addr_width - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [Addr_width:0] rbin_s;
  logic [Addr_width:0] used_s;
  logic                af_d;
  logic                af_q;

  // Occupancy seen against the synchronised read pointer
  always_comb begin
    rbin_s = gray2bin(rq2_q);
    used_s = wbin_d - rbin_s;
    af_d   = (used_s >= AF_THRESH);
  end

  // Almost-full register
  always_ff @(posedge Wr_clk) begin
    if (rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign Almost_full = af_q;
`endif

endmodule

// File: tb/tb_wr_full_ctrl.sv
// Directed self-checking bench for wr_full_ctrl (Addr_width=5); almost-full steps
// are compiled in only when ALMOST_FULL_EN is defined.
module tb_wr_full_ctrl;
  localparam int AW = 5;

  logic          Wr_clk = 1'b0;
  logic          rst;
  logic          Wr_en;
  logic [AW:0]   Rd_point_gray;
  logic [AW-1:0] Wr_addr;
  logic [AW:0]   Wr_point;
  logic          Mem_wr_en;
  logic          Full_sig;
  logic          Ovf_err;
`ifdef ALMOST_FULL_EN
  logic          Almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  wr_full_ctrl #(.Addr_width(AW), .AF_margin(2)) dut (
    .Wr_clk        (Wr_clk),
    .rst           (rst),
    .Wr_en         (Wr_en),
    .Rd_point_gray (Rd_point_gray),
    .Wr_addr       (Wr_addr),
    .Wr_point      (Wr_point),
    .Mem_wr_en     (Mem_wr_en),
    .Full_sig      (Full_sig),
    .Ovf_err       (Ovf_err)
`ifdef ALMOST_FULL_EN
    ,
    .Almost_full   (Almost_full)
`endif
  );

  always #5 Wr_clk = ~Wr_clk;

  function automatic logic [AW:0] g(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Wr_clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    Wr_en         = 1'b0;
    Rd_point_gray = 6'd0;

    // Reset values
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_addr", 32'(Wr_addr), 32'd0);
    chk("rst_ptr", 32'(Wr_point), 32'd0);
    chk("rst_full", 32'(Full_sig), 32'd0);
    chk("rst_ovf", 32'(Ovf_err), 32'd0);
    chk("rst_mem", 32'(Mem_wr_en), 32'd0);

    // Fill to full with 33 requests
    for (int i = 0; i < 33; i++) begin
      Wr_en = 1'b1;
      #1;
      if (Mem_wr_en === 1'b1) n_acc++;
      chk("fill_addr", 32'(Wr_addr), 32'(i % 32));
      cyc();
      chk("fill_full", 32'(Full_sig), 32'(i >= 31));
      chk("fill_ovf", 32'(Ovf_err), 32'(i >= 32));
      chk("fill_ptr", 32'(Wr_point), 32'(g(6'((i < 32) ? i + 1 : 32))));
    end
    chk("fill_count", 32'(n_acc), 32'd32);
    chk("fill_ptr_end", 32'(Wr_point), 32'(6'b110000));
    chk("fill_addr_end", 32'(Wr_addr), 32'd0);

    // Release from full: three edges of synchroniser lag
    Wr_en         = 1'b0;
    Rd_point_gray = 6'b000001;
    cyc();
    chk("rel_full_e1", 32'(Full_sig), 32'd1);
    cyc();
    chk("rel_full_e2", 32'(Full_sig), 32'd1);
    cyc();
    chk("rel_full_e3", 32'(Full_sig), 32'd0);
    Wr_en = 1'b1;
    #1;
    chk("rel_mem", 32'(Mem_wr_en), 32'd1);
    chk("rel_addr", 32'(Wr_addr), 32'd0);
    cyc();
    Wr_en = 1'b0;
    chk("rel_addr_next", 32'(Wr_addr), 32'd1);
    chk("rel_ptr_next", 32'(Wr_point), 32'(6'b110001));
    chk("rel_full_again", 32'(Full_sig), 32'd1);
    chk("rel_ovf_sticky", 32'(Ovf_err), 32'd1);

    // Reset clears the sticky overflow
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_ovf", 32'(Ovf_err), 32'd0);
    chk("rst2_full", 32'(Full_sig), 32'd0);
    chk("rst2_ptr", 32'(Wr_point), 32'd0);

    // Wrap-around with the read pointer lagging by four entries
    for (int k = 0; k < 64; k++) begin
      Wr_en         = 1'b1;
      Rd_point_gray = g(6'(k - 4));
      #1;
      chk("wrap_mem", 32'(Mem_wr_en), 32'd1);
      cyc();
      chk("wrap_full", 32'(Full_sig), 32'd0);
      chk("wrap_addr", 32'(Wr_addr), 32'((k + 1) % 32));
      chk("wrap_ptr", 32'(Wr_point), 32'(g(6'(k + 1))));
    end
    chk("wrap_ptr_end", 32'(Wr_point), 32'd0);
    chk("wrap_addr_end", 32'(Wr_addr), 32'd0);

    // Reset in the middle of a burst
    Rd_point_gray = 6'd0;
    for (int k = 0; k < 10; k++) begin
      Wr_en = 1'b1;
      #1;
      chk("burst_mem", 32'(Mem_wr_en), 32'd1);
      cyc();
    end
    chk("burst_addr", 32'(Wr_addr), 32'd10);
    rst = 1'b1;
    #1;
    chk("mid_rst_mem", 32'(Mem_wr_en), 32'd0);
    cyc();
    rst   = 1'b0;
    Wr_en = 1'b0;
    chk("mid_rst_addr", 32'(Wr_addr), 32'd0);
    chk("mid_rst_ptr", 32'(Wr_point), 32'd0);
    chk("mid_rst_full", 32'(Full_sig), 32'd0);
    chk("mid_rst_ovf", 32'(Ovf_err), 32'd0);
    Wr_en = 1'b1;
    #1;
    chk("post_rst_mem", 32'(Mem_wr_en), 32'd1);
    cyc();
    Wr_en = 1'b0;
    chk("post_rst_addr", 32'(Wr_addr), 32'd1);

`ifdef ALMOST_FULL_EN
    // Almost-full after 30 accepted writes with a margin of two
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("af_rst", 32'(Almost_full), 32'd0);
    for (int k = 0; k < 30; k++) begin
      Wr_en = 1'b1;
      cyc();
      chk("af_fill", 32'(Almost_full), 32'(k >= 29));
    end
    Wr_en = 1'b0;
    rst   = 1'b1;
    cyc();
    rst = 1'b0;
    chk("af_rst_end", 32'(Almost_full), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wr_full_ctrl.md
# wr_full_ctrl

Write-side pointer and full-flag controller for the asynchronous FIFO. It runs entirely in the write clock domain and maintains the binary and Gray write pointers. It double-flop-synchronises the Gray read pointer coming from the read domain and produces a registered `Full_sig`, a gated memory write enable and a sticky overflow error. It is the write-end counterpart of the read-side empty detection: the Gray write pointer it exports is what the read domain synchronises and compares against its own read pointer.

## Interface

- `Addr_width`, default 5: FIFO address width. Depth is 2^`Addr_width`. Pointers are `Addr_width+1` bits. Minimum value is 2.
- `AF_margin`, default 2: almost-full threshold in free entries. Used only when `ALMOST_FULL_EN` is defined.

Ports:
- `Wr_clk` — input, 1 bit: write-domain clock. All flops are on its rising edge.
- `rst` — input, 1 bit: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `Wr_en` — input, 1 bit: write request for the current cycle.
- `Rd_point_gray` — input, `Addr_width+1` bits: Gray-coded read pointer, asynchronous to `Wr_clk`.
- `Wr_addr` — output, `Addr_width` bits: memory write address, equal to the low bits of the binary write pointer.
- `Wr_point` — output, `Addr_width+1` bits: registered Gray write pointer, exported to the read domain.
- `Mem_wr_en` — output, 1 bit: memory write strobe.
- `Full_sig` — output, 1 bit: registered full flag.
- `Ovf_err` — output, 1 bit: sticky error flag; set when a write is attempted while full.
- `Almost_full` — output, 1 bit: almost-full flag. This port exists only when `ALMOST_FULL_EN` is defined.

## Operation

- **Registers:**
  - `wbin`: binary write pointer, `Addr_width+1` bits.
  - `Wr_point`: Gray write pointer.
  - `rq1` and `rq2`: synchroniser stages for the read pointer.
  - `Full_sig` and `Ovf_err`.
- **Accepted write:** a write is accepted when `acc = Wr_en & ~Full_sig & ~rst`. `Mem_wr_en = acc`, combinational.
- **Next pointer:** `wbin_next = wbin + acc`, modulo 2^(`Addr_width+1`). `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- **Register updates on each edge (not in reset):**
  - `wbin <= wbin_next`
  - `Wr_point <= wgray_next`
  - `rq1 <= Rd_point_gray`
  - `rq2 <= rq1`
- **Full condition:**
  - `Full_sig <= (wgray_next == {~rq2[Addr_width:Addr_width-1], rq2[Addr_width-2:0]})`.
  - The flag is therefore valid in the same cycle the last free slot is consumed.
- **Overflow:** `Ovf_err <= Ovf_err | (Wr_en & Full_sig)`. It is cleared only by `rst`. The rejected write leaves all pointers unchanged.
- **Wrap-around:** `wbin` wraps from 2^(`Addr_width+1`)-1 to 0. The MSB toggle distinguishes full from empty; no special case is needed.
- **Write while full, read pointer advancing:** the write is rejected in that cycle, based on the registered `Full_sig`. It is accepted in the cycle after `Full_sig` falls.
- **Reset, including mid-operation:** on the next edge with `rst`=1, the following are all cleared to 0:
  - `wbin`, `Wr_point`, `rq1`, `rq2`, `Full_sig`, `Ovf_err` (and `Almost_full` when present).

  `Mem_wr_en` is 0 throughout reset, and an in-flight write is discarded. After reset `Wr_addr`=0 and `Wr_point`=0.

## Timing

- **Write accept to pointer:** a write is accepted in cycle N. `Wr_addr` and `Wr_point` show the advanced value after edge N.
- **Read-pointer change to `Full_sig`:**
  - The change enters `rq1` at edge 1 and `rq2` at edge 2.
  - `Full_sig` reflects it after edge 3.
  - Free space is therefore reported up to 3 cycles late, which is conservative.
- **`Full_sig` assertion:** asserts after the edge that accepts the write filling the last slot, with zero cycles of lag.
- **Gray stability:** `Wr_point` is a register output and changes at most 1 bit per edge. It is safe for the read-domain synchroniser.

## Configuration

- **`ALMOST_FULL_EN` defined:**
  - Add the `Almost_full` output and Gray-to-binary conversion of `rq2` into `rbin_s`.
  - `Almost_full <= ((wbin_next - rbin_s) mod 2^(Addr_width+1)) >= 2^Addr_width - AF_margin`.
  - The flag resets to 0 and follows the same 3-edge synchroniser lag as `Full_sig`.
- **`ALMOST_FULL_EN` not defined:** no `Almost_full` port, no conversion logic, and `AF_margin` is unused.

## Test plan

1. **Reset values:** `rst`=1 for 2 cycles, then release with `Wr_en`=0. Required: all outputs 0, `Wr_point`=6'b000000.
2. **Fill to full:**
   - Stimulus: `Rd_point_gray`=0; hold `Wr_en`=1 for 33 cycles.
   - Required: `Mem_wr_en` is high for exactly 32 cycles; `Wr_addr` runs 0..31 then returns to 0; `Full_sig`=1 after the 32nd accept; `Wr_point`=6'b110000.
   - Required: the 33rd request is rejected, `Ovf_err`=1, and the pointer is unchanged.
3. **Release from full:** from the full state, set `Rd_point_gray`=6'b000001. Required: `Full_sig` falls after exactly 3 edges; the next `Wr_en` is accepted at `Wr_addr`=0.
4. **Wrap-around:**
   - Stimulus: 64 writes with `Rd_point_gray` tracking the write pointer, lagging by 4 entries.
   - Required: `Full_sig` is never set; `wbin` wraps to 0 and `Wr_point` returns to 6'b000000.
5. **Reset mid-burst:** assert `rst` for 1 cycle during a write burst at `Wr_addr`=10. Required: `Mem_wr_en`=0 in that cycle, all pointers are 0 at the next edge, and `Ovf_err` is cleared.
6. **Almost-full (with `ALMOST_FULL_EN`):** `AF_margin`=2, `Rd_point_gray`=0. Required: `Almost_full`=1 after the 30th accepted write and 0 after reset.
